// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 keyboard receiver bus: raw PS/2 lines in, decoded key and frame status out.
interface ps2_keyboard_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] kbd_signal;
  logic       kbd_ready;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  // Receiver side: samples the PS/2 lines, drives key/frame results.
  modport master (
    input  ps2_clk, ps2_data,
    output kbd_signal, kbd_ready, scan_code, scan_valid, frame_err
  );

  // Keyboard/consumer side: drives the PS/2 lines, observes results.
  modport slave (
    output ps2_clk, ps2_data,
    input  kbd_signal, kbd_ready, scan_code, scan_valid, frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 Set-2 receiver: synchronize + filter ps2_clk, frame 11-bit words,
// decode make/break codes into upper-case ASCII with a held-key flag.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input logic              clk,
  input logic              rst,
  ps2_keyboard_rx_if.master bus
);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FLAST = FCW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]     clk_s, dat_s;
  logic           filt, fall;
  logic [FCW-1:0] fcnt;
  logic [TW-1:0]  tmo;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       par_bit, par_n;
  logic [7:0] code_q, code_n;
  logic       sv_q, sv_n, fe_q, fe_n;

  logic       brk, ext;
  logic [7:0] key_q, dec_ascii;
  logic       rdy_q;

  // Set-2 scan code to upper-case ASCII; 0x00 for anything unmapped.
  function automatic logic [7:0] ascii_of(input logic [7:0] sc);
    case (sc)
      8'h1C: ascii_of = "A";  8'h32: ascii_of = "B";  8'h21: ascii_of = "C";
      8'h23: ascii_of = "D";  8'h24: ascii_of = "E";  8'h2B: ascii_of = "F";
      8'h34: ascii_of = "G";  8'h33: ascii_of = "H";  8'h43: ascii_of = "I";
      8'h3B: ascii_of = "J";  8'h42: ascii_of = "K";  8'h4B: ascii_of = "L";
      8'h3A: ascii_of = "M";  8'h31: ascii_of = "N";  8'h44: ascii_of = "O";
      8'h4D: ascii_of = "P";  8'h15: ascii_of = "Q";  8'h2D: ascii_of = "R";
      8'h1B: ascii_of = "S";  8'h2C: ascii_of = "T";  8'h3C: ascii_of = "U";
      8'h2A: ascii_of = "V";  8'h1D: ascii_of = "W";  8'h22: ascii_of = "X";
      8'h35: ascii_of = "Y";  8'h1A: ascii_of = "Z";
      8'h45: ascii_of = "0";  8'h16: ascii_of = "1";  8'h1E: ascii_of = "2";
      8'h26: ascii_of = "3";  8'h25: ascii_of = "4";  8'h2E: ascii_of = "5";
      8'h36: ascii_of = "6";  8'h3D: ascii_of = "7";  8'h3E: ascii_of = "8";
      8'h46: ascii_of = "9";
      8'h29: ascii_of = 8'h20;
      8'h5A: ascii_of = 8'h0D;
      default: ascii_of = 8'h00;
    endcase
  endfunction

  // Two-flop synchronizers; reset to the idle-high bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], bus.ps2_clk};
      dat_s <= {dat_s[0], bus.ps2_data};
    end
  end

  // Glitch filter: accept a level change only after FILTER_LEN equal samples;
  // fall strobes for one cycle when the filtered clock drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s[1] != filt) begin
        if (fcnt == FLAST) begin
          filt <= clk_s[1];
          fcnt <= '0;
          fall <= ~clk_s[1];
        end else begin
          fcnt <= fcnt + FCW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // Inactivity counter: restarts on every bit edge and while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          tmo <= '0;
    else if (state == IDLE || fall)   tmo <= '0;
    else if (tmo != TMAX)             tmo <= tmo + TW'(1);
  end

  // Frame FSM state and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      code_q  <= '0;
      sv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_bit <= par_n;
      code_q  <= code_n;
      sv_q    <= sv_n;
      fe_q    <= fe_n;
    end
  end

  // Frame FSM next state: timeout wins over a coincident bit edge.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_bit;
    code_n    = code_q;
    sv_n      = 1'b0;
    fe_n      = 1'b0;
    if (state != IDLE && tmo == TMAX) begin
      state_n = IDLE;
      fe_n    = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s[1]) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end else begin
            fe_n = 1'b1;
          end
        end
        DATA: begin
          shreg_n   = {dat_s[1], shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s[1];
          state_n = STOP;
        end
        STOP: begin
          if (dat_s[1] && ((^shreg) ^ par_bit)) begin
            code_n = shreg;
            sv_n   = 1'b1;
          end else begin
            fe_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign dec_ascii = ext ? 8'h00 : ascii_of(code_q);

  // Make/break decoder: key value is held through release so the downstream
  // stage sees a stable value on the falling edge of kbd_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk   <= 1'b0;
      ext   <= 1'b0;
      key_q <= '0;
      rdy_q <= 1'b0;
    end else if (sv_q) begin
      if (code_q == 8'hF0) begin
        brk <= 1'b1;
      end else if (code_q == 8'hE0) begin
        ext <= 1'b1;
      end else begin
        brk <= 1'b0;
        ext <= 1'b0;
        if (dec_ascii != 8'h00) begin
          if (!brk) begin
            key_q <= dec_ascii;
            rdy_q <= 1'b1;
          end else if (dec_ascii == key_q) begin
            rdy_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.kbd_signal = key_q;
  assign bus.kbd_ready  = rdy_q;
  assign bus.scan_code  = code_q;
  assign bus.scan_valid = sv_q;
  assign bus.frame_err  = fe_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench: stimulus pushes expected frame events and key-state
// changes; monitors pop and compare whenever the DUT presents them.
module tb_ps2_keyboard_rx;
  localparam int FLEN = 8;
  localparam int TMO  = 3000;
  localparam int HALF = 20;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       tmo_chk;
  } ev_t;

  typedef struct {
    logic [7:0] sig;
    logic       rdy;
  } key_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  ev_t  ev_q[$];
  key_t key_q[$];
  key_t prev_key = '{8'h00, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-event monitor.
  always @(negedge clk) begin
    if (!rst && (bus.scan_valid || bus.frame_err)) begin
      ev_t e;
      checks++;
      if (bus.scan_valid && bus.frame_err) begin
        failures++;
        $display("FAIL both_pulses: scan_valid and frame_err high together at cycle %0d", cyc);
      end else if (ev_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: valid=%0b err=%0b code=%02h at cycle %0d",
                 bus.scan_valid, bus.frame_err, bus.scan_code, cyc);
      end else begin
        e = ev_q.pop_front();
        if (e.err != bus.frame_err || (!e.err && bus.scan_code != e.code)) begin
          failures++;
          $display("FAIL frame_event: got err=%0b code=%02h, want err=%0b code=%02h",
                   bus.frame_err, bus.scan_code, e.err, e.code);
        end
        if (e.tmo_chk) begin
          checks++;
          if (cyc < last_fall_cyc + TMO || cyc > last_fall_cyc + TMO + 30) begin
            failures++;
            $display("FAIL timeout_cycle: got cycle %0d, want within [%0d,%0d]",
                     cyc, last_fall_cyc + TMO, last_fall_cyc + TMO + 30);
          end
        end
      end
    end
  end

  // Key-state monitor: every change of {kbd_signal,kbd_ready} must be expected.
  always @(negedge clk) begin
    key_t cur;
    cur = '{bus.kbd_signal, bus.kbd_ready};
    if (cur != prev_key) begin
      checks++;
      if (key_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_key: got sig=%02h rdy=%0b at cycle %0d", cur.sig, cur.rdy, cyc);
      end else begin
        key_t k;
        k = key_q.pop_front();
        if (k != cur) begin
          failures++;
          $display("FAIL key_state: got sig=%02h rdy=%0b, want sig=%02h rdy=%0b",
                   cur.sig, cur.rdy, k.sig, k.rdy);
        end
      end
      prev_key = cur;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    bus.ps2_data = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  task automatic good(input logic [7:0] b);
    ev_q.push_back('{1'b0, b, 1'b0});
    send_frame(b, 1'b0);
  endtask

  task automatic exp_key(input logic [7:0] s, input logic r);
    key_q.push_back('{s, r});
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %02h, want %02h", name, got, want);
    end
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cyc(5);
    chk("reset_kbd_signal", bus.kbd_signal, 8'h00);
    chk("reset_kbd_ready",  {7'd0, bus.kbd_ready}, 8'h00);
    chk("reset_scan_code",  bus.scan_code, 8'h00);
    chk("reset_scan_valid", {7'd0, bus.scan_valid}, 8'h00);
    chk("reset_frame_err",  {7'd0, bus.frame_err}, 8'h00);
    rst = 1'b0;
    wait_cyc(20);

    // Press and release W.
    exp_key(8'h57, 1'b1); good(8'h1D);
    good(8'hF0);
    exp_key(8'h57, 1'b0); good(8'h1D);

    // Parity error: no decode, no key change.
    ev_q.push_back('{1'b1, 8'h00, 1'b0});
    send_frame(8'h1C, 1'b1);

    // Mid-frame timeout after 5 bits, then a clean frame.
    ev_q.push_back('{1'b1, 8'h00, 1'b1});
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.ps2_data = 1'b1;
    wait_cyc(TMO + 500);
    exp_key(8'h44, 1'b1); good(8'h23);

    // Extended code ignored; overlapping keys.
    good(8'hE0); good(8'h75);
    exp_key(8'h41, 1'b1); good(8'h1C);
    exp_key(8'h44, 1'b1); good(8'h23);
    good(8'hF0); good(8'h1C);
    exp_key(8'h44, 1'b0); good(8'hF0); good(8'h23);

    // Glitch on ps2_clk in idle must be ignored.
    bus.ps2_clk = 1'b0;
    wait_cyc(3);
    bus.ps2_clk = 1'b1;
    wait_cyc(50);

    // Reset mid-frame after data bit 4.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    exp_key(8'h00, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_kbd_signal", bus.kbd_signal, 8'h00);
    chk("midrst_kbd_ready",  {7'd0, bus.kbd_ready}, 8'h00);
    chk("midrst_scan_code",  bus.scan_code, 8'h00);
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
    exp_key(8'h53, 1'b1); good(8'h1B);

    wait_cyc(200);
    chk("events_left", 8'(ev_q.size()), 8'h00);
    chk("keys_left",   8'(key_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives PS/2 Set-2 scan codes from a keyboard, checks each 11-bit frame, and decodes make/break codes into an 8-bit upper-case ASCII key value with a held-key flag. It sits directly upstream of the VGA square-mover display stage and drives that stage's `kbd_signal` and `kbd_ready` inputs. The display stage acts on the falling edge of `kbd_ready`, which this block produces on key release.

## Interface
- `FILTER_LEN`, default 8: consecutive identical `clk` samples required before a `ps2_clk` level change is accepted.
- `TIMEOUT_CYCLES`, default 65000: `clk` cycles without a PS/2 falling edge, mid-frame, before the frame is aborted. At 65 MHz this is 1 ms.
- `clk` in 1: system/pixel clock, 65 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data, asynchronous to `clk`.
- `kbd_signal` out 8: ASCII of the last decoded key. Held stable until another mapped make code arrives.
- `kbd_ready` out 1: high while the key in `kbd_signal` is held down.
- `scan_code` out 8: last valid raw byte received.
- `scan_valid` out 1: one-cycle pulse per valid frame.
- `frame_err` out 1: one-cycle pulse on a start, parity, stop or timeout error.

## Operation
- **Input conditioning**
  - Two-flop synchronizer on each of `ps2_clk` and `ps2_data`.
  - Filtered clock changes state only after `FILTER_LEN` equal synchronized samples.
  - Filtered falling edge is a one-cycle `fall` strobe. Data is sampled from the synchronized `ps2_data` on `fall`.
- **Frame FSM** (acts only on `fall`, except for timeout):
  - IDLE: data=0 → DATA with bit count 0. Data=1 → stay in IDLE and pulse `frame_err`.
  - DATA: shift in 8 bits LSB first, then go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: require stop=1 and odd parity (XOR of 8 data bits and parity = 1).
    - Pass: latch `scan_code` and pulse `scan_valid`.
    - Fail: pulse `frame_err` and leave `scan_code` unchanged.
    - Either way, return to IDLE.
  - Timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits. It is cleared on every `fall` and in IDLE. On reaching `TIMEOUT_CYCLES` outside IDLE: go to IDLE, pulse `frame_err`, discard partial bits.
- **Decoder** (acts on `scan_valid`):
  - 0xF0: set the `brk` flag.
  - 0xE0: set the `ext` flag.
  - Any other byte:
    - Map the byte to ASCII; unmapped codes give 0x00.
    - If `ext` is set, treat the byte as unmapped.
    - Clear `brk` and `ext` after the byte is processed.
  - Make, mapped: `kbd_signal` ← ASCII and `kbd_ready` ← 1.
    - A repeated make of the same key (typematic) leaves the outputs unchanged.
    - A make of a different key while one is held replaces `kbd_signal` and keeps `kbd_ready` at 1.
  - Break, mapped, ASCII equal to `kbd_signal`: `kbd_ready` ← 0 and `kbd_signal` is held.
  - Break of any other key, or any unmapped code: no output change.
- **Map** (Set 2 scan code → ASCII):
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Digits: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
  - Other: 29 → 0x20, 5A → 0x0D.
- **Reset**
  - All outputs go to 0.
  - FSM goes to IDLE; `brk`, `ext`, counters and filter state are cleared.
  - Filtered clock and synchronizers reset to 1 (bus idle).
  - A reset mid-frame discards the frame.

## Timing
- `fall` lags the raw `ps2_clk` edge by 2 synchronizer cycles plus `FILTER_LEN` cycles.
- `scan_valid` and `frame_err` are asserted on the cycle after the stop-bit `fall`.
- `kbd_signal`, `kbd_ready` and the `brk`/`ext` flags update on the cycle after `scan_valid`.
- `scan_code` updates in the same cycle as `scan_valid`.
- `scan_valid` and `frame_err` are never high together.
- `kbd_signal` must not change in the cycle `kbd_ready` falls, so the downstream stage samples a stable key value on that edge.
- PS/2 bit period is 60–100 µs. The filter must reject glitches shorter than `FILTER_LEN` cycles.

## Test plan
- **Press and release of W:** frames 1D, F0, 1D → `kbd_ready` rises after the first frame with `kbd_signal`=0x57; `kbd_ready` falls after the final 1D with `kbd_signal` still 0x57; 3 `scan_valid` pulses.
- **Parity error:** byte 1C sent with even parity → `frame_err` pulse; no `scan_valid`; `kbd_signal` and `kbd_ready` unchanged.
- **Mid-frame timeout:** 5 bits sent, then the clock stops for 70000 cycles → `frame_err` pulse at cycle `TIMEOUT_CYCLES`. A following full frame 23 decodes cleanly to 0x44 with `kbd_ready`=1.
- **Extended and overlapping keys:**
  - E0 75 → no output change.
  - Then 1C, 23 → `kbd_signal` 0x41 then 0x44, `kbd_ready` held at 1.
  - Then F0 1C → `kbd_ready` stays 1.
  - Then F0 23 → `kbd_ready` falls to 0.
- **Glitch rejection:** a 3-cycle low pulse on `ps2_clk` in IDLE → no `fall`, no `frame_err`.
- **Reset mid-frame:** `rst` asserted after bit 4 of a frame → all outputs 0 immediately. A full frame 1B after release gives `kbd_signal`=0x53.
